jk_excite_seq: RTL and testbench
================================

JK_EXCITE_SEQ -- requirements
Module: jk_excite_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of JK register bits, legal range 1..16.
REQ-002 SHALL have parameter SERIAL, default 0: 0 = all bits excited in one cycle; 1 = one bit per cycle, LSB first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tgt_valid, input, 1 bit: a target word is offered.
REQ-006 SHALL have port tgt_data, input, WIDTH bits: the desired next register value.
REQ-007 SHALL have port tgt_ready, output, 1 bit: block can accept a target.
REQ-008 SHALL have port j_out, output, WIDTH bits: J excitation currently applied to the internal JK bank.
REQ-009 SHALL have port k_out, output, WIDTH bits: K excitation currently applied to the internal JK bank.
REQ-010 SHALL have port q, output, WIDTH bits: internal JK register bank state.
REQ-011 SHALL have port busy, output, 1 bit: a target is being applied.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when an application completes.
REQ-013 SHALL have port mismatch, output, 1 bit: with done, q differs from the latched target.

Function
REQ-014 SHALL implement the JK bank as q[i] <= J?(K?~q[i]:1):(K?0:q[i]) per bit, using only j_out/k_out.
REQ-015 SHALL use FSM states IDLE, EXCITE, CHECK; IDLE->EXCITE on tgt_valid&&tgt_ready, EXCITE->CHECK after the last excite cycle, CHECK->IDLE unconditionally.
REQ-016 SHALL drive tgt_ready=1 only in IDLE; busy=1 in EXCITE and CHECK.
REQ-017 SHALL latch tgt_data into an internal target register on the accepting edge.
REQ-018 SHALL derive excitation per bit from the excitation table: 0->0 J=0,K=0; 1->1 J=0,K=0; 0->1 and 1->0 per REQ-033/034.
REQ-019 SHALL drive j_out=k_out=0 in IDLE and CHECK, and for non-selected bits in serial mode.
REQ-020 SERIAL=0: EXCITE lasts exactly one cycle; all bits excited together.
REQ-021 SERIAL=1: EXCITE lasts exactly WIDTH cycles; bit-index counter starts at 0, selects bit idx, increments each cycle, EXCITE->CHECK when idx==WIDTH-1.
REQ-022 Latency: accept edge at cycle n; done high in cycle n+2 (SERIAL=0) or n+WIDTH+1 (SERIAL=1); tgt_ready high again the following cycle.
REQ-023 SHALL assert done for exactly one cycle in CHECK; mismatch = (q != target) in the same cycle, else 0.
REQ-024 Target equal to current q: full FSM sequence still runs, all J/K=0, done pulses, mismatch=0.
REQ-025 tgt_valid while busy: ignored, not latched, no back-pressure effect besides tgt_ready=0.
REQ-026 tgt_data changes after acceptance: no effect on the application in progress.
REQ-027 Back-to-back targets: next accept earliest in the cycle after CHECK.

Reset
REQ-028 rst=1 SHALL immediately force FSM=IDLE, q=0, target=0, idx=0.
REQ-029 During reset SHALL drive j_out=0, k_out=0, busy=0, done=0, mismatch=0, tgt_ready=0.
REQ-030 After rst deasserts, tgt_ready=1 from the first cycle.
REQ-031 Reset mid-EXCITE or mid-CHECK SHALL abort; no done pulse; partially applied q cleared.
REQ-032 No tgt_valid accepted on the edge coinciding with rst=1.

Configuration
REQ-033 Macro JK_TOGGLE_EXCITE_EN defined: changing bits use toggle, J=1,K=1.
REQ-034 Macro undefined: 0->1 uses J=1,K=0; 1->0 uses J=0,K=1; final q identical in both builds.

Verification
REQ-035 WIDTH=4, SERIAL=0, reset, offer 4'b1010 -> j_out=1010, k_out=0000 one cycle; q=1010 and done=1, mismatch=0 next cycle.
REQ-036 From q=1010 offer 4'b0110 -> undefined: j_out=0100,k_out=1000; defined: j_out=k_out=1100; q=0110 either way.
REQ-037 SERIAL=1, q=0000, offer 4'b1111 -> q steps 0001,0011,0111,1111 on successive edges; done 5 cycles after accept.
REQ-038 Offer 4'b0011 with tgt_valid held high through CHECK, tgt_data changed to 4'b1100 -> only 0011 applied; 1100 accepted next IDLE cycle.
REQ-039 SERIAL=1, assert rst after 2 excite cycles -> q=0000, busy=0, no done; subsequent 4'b0101 completes normally.
REQ-040 Offer value equal to current q (4'b0110) -> j_out=k_out=0000 throughout, done=1, mismatch=0.

Source files
------------

// File: rtl/jk_excite_seq.sv
// jk_excite_seq: steers an internal JK register bank to a requested target word using
// excitation-table J/K values. Optional macro JK_TOGGLE_EXCITE_EN: changing bits use J=K=1.
module jk_excite_seq #(
    parameter int WIDTH  = 4,
    parameter int SERIAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [1:0]       fsm_state
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXCITE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] target;
    logic [IDXW-1:0]  idx, idx_nxt;
    logic             accept;
    logic             last_excite;
    logic [WIDTH-1:0] diff, sel, j_raw, k_raw;

    // tgt_valid/tgt_ready: a target transfers on a rising clk edge where both are high;
    // while tgt_ready is low, tgt_valid and tgt_data are ignored and may change freely.
    assign tgt_ready = (state == IDLE) && !rst;
    assign fsm_state = state;

    always_comb begin
        diff = q ^ target;
`ifdef JK_TOGGLE_EXCITE_EN
        j_raw = diff;
        k_raw = diff;
`else
        j_raw = target & diff;
        k_raw = q & diff;
`endif
        // Serial mode drives only the bit addressed by idx; the rest stay in hold.
        sel = (SERIAL != 0) ? (WIDTH'(1) << idx) : '1;
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mismatch    = 1'b0;
        j_out       = '0;
        k_out       = '0;
        last_excite = (SERIAL == 0) || (idx == IDXW'(WIDTH - 1));
        case (state)
            IDLE: begin
                accept = tgt_valid;
                if (accept) begin
                    state_nxt = EXCITE;
                    idx_nxt   = '0;
                end
            end
            EXCITE: begin
                busy  = 1'b1;
                j_out = j_raw & sel;
                k_out = k_raw & sel;
                if (last_excite) begin
                    state_nxt = CHECK;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                done      = 1'b1;
                mismatch  = (q != target);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            target <= '0;
            q      <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                target <= tgt_data;
            end
            // The bank sees nothing but j_out/k_out, exactly like discrete JK flops.
            for (int i = 0; i < WIDTH; i++) begin
                q[i] <= j_out[i] ? (k_out[i] ? ~q[i] : 1'b1) : (k_out[i] ? 1'b0 : q[i]);
            end
        end
    end
endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: a parallel (SERIAL=0) and a serial (SERIAL=1) instance, both
// WIDTH=4, checked every cycle against a transaction-level model plus directed literals.
module tb_jk_excite_seq;
    localparam int W = 4;

    typedef struct packed {
        logic         ready;
        logic         busy;
        logic         done;
        logic         mismatch;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] q;
    } exp_t;

    logic         clk = 1'b0;
    logic [1:0]   rst_v;
    logic [1:0]   valid_v;
    logic [W-1:0] data_v [2];

    logic         ready0, busy0, done0, mm0;
    logic         ready1, busy1, done1, mm1;
    logic [W-1:0] j0, k0, q0, j1, k1, q1;
    logic [1:0]   st0, st1;

    int checks = 0;
    int errors = 0;

    exp_t         exp_q [2][$];
    logic [W-1:0] qm [2];

    always #5 clk = ~clk;

    jk_excite_seq #(.WIDTH(W), .SERIAL(0)) u_par (
        .clk(clk), .rst(rst_v[0]), .tgt_valid(valid_v[0]), .tgt_data(data_v[0]),
        .tgt_ready(ready0), .j_out(j0), .k_out(k0), .q(q0), .busy(busy0),
        .done(done0), .mismatch(mm0), .fsm_state(st0)
    );

    jk_excite_seq #(.WIDTH(W), .SERIAL(1)) u_ser (
        .clk(clk), .rst(rst_v[1]), .tgt_valid(valid_v[1]), .tgt_data(data_v[1]),
        .tgt_ready(ready1), .j_out(j1), .k_out(k1), .q(q1), .busy(busy1),
        .done(done1), .mismatch(mm1), .fsm_state(st1)
    );

    task automatic cmp(input string what, input int d, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %b expected %b", what, d, $time, got, want);
        end
    endtask

    // Expected per-cycle trace of one application: excite cycles, then the check cycle.
    task automatic plan(input int d, input logic [W-1:0] t);
        logic [W-1:0] cur, diff, jf, kf, low, m;
        exp_t e;
        cur  = qm[d];
        diff = cur ^ t;
`ifdef JK_TOGGLE_EXCITE_EN
        jf = diff;
        kf = diff;
`else
        jf = t & diff;
        kf = cur & diff;
`endif
        if (d == 0) begin
            e = {1'b0, 1'b1, 1'b0, 1'b0, jf, kf, cur};
            exp_q[d].push_back(e);
        end else begin
            for (int b = 0; b < W; b++) begin
                low = W'((1 << b) - 1);
                m   = W'(1 << b);
                e   = {1'b0, 1'b1, 1'b0, 1'b0, jf & m, kf & m, (t & low) | (cur & ~low)};
                exp_q[d].push_back(e);
            end
        end
        e = {1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, t};
        exp_q[d].push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t act [2];
        exp_t e;
        bit   idle;
        act[0] = {ready0, busy0, done0, mm0, j0, k0, q0};
        act[1] = {ready1, busy1, done1, mm1, j1, k1, q1};
        for (int d = 0; d < 2; d++) begin
            idle = 1'b0;
            if (rst_v[d]) begin
                e = '0;
                exp_q[d].delete();
                qm[d] = '0;
            end else if (exp_q[d].size() == 0) begin
                e    = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, qm[d]};
                idle = 1'b1;
            end else begin
                e = exp_q[d].pop_front();
                if (e.done) qm[d] = e.q;
            end
            cmp("tgt_ready", d, W'(act[d].ready), W'(e.ready));
            cmp("busy", d, W'(act[d].busy), W'(e.busy));
            cmp("done", d, W'(act[d].done), W'(e.done));
            cmp("mismatch", d, W'(act[d].mismatch), W'(e.mismatch));
            cmp("j_out", d, act[d].j, e.j);
            cmp("k_out", d, act[d].k, e.k);
            cmp("q", d, act[d].q, e.q);
            if (idle && valid_v[d]) plan(d, data_v[d]);
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (rdy(d) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        cmp("ready_timeout", d, W'(rdy(d)), W'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v     = 2'b11;
        valid_v   = 2'b00;
        data_v[0] = '0;
        data_v[1] = '0;
        tick();
        cmp("lit_rst_ready", 0, W'(ready0), W'(1'b0));
        cmp("lit_rst_busy", 1, W'(busy1), W'(1'b0));
        cmp("lit_rst_q", 0, q0, 4'b0000);
        tick();
        rst_v = 2'b00;
        #1;
        cmp("lit_ready_after_rst", 0, W'(ready0), W'(1'b1));
        cmp("lit_ready_after_rst", 1, W'(ready1), W'(1'b1));

        // Parallel: 0000 -> 1010
        tick();
        wait_ready(0);
        valid_v[0] = 1'b1; data_v[0] = 4'b1010;
        tick();
        valid_v[0] = 1'b0;
        #1;
        cmp("lit_j_1010", 0, j0, 4'b1010);
        cmp("lit_k_1010", 0, k0, 4'b0000);
        tick(); #1;
        cmp("lit_q_1010", 0, q0, 4'b1010);
        cmp("lit_done_1010", 0, W'(done0), W'(1'b1));
        cmp("lit_mm_1010", 0, W'(mm0), W'(1'b0));

        // Parallel: 1010 -> 0110
        tick();
        wait_ready(0);
        valid_v[0] = 1'b1; data_v[0] = 4'b0110;
        tick();
        valid_v[0] = 1'b0;
        #1;
`ifdef JK_TOGGLE_EXCITE_EN
        cmp("lit_j_0110", 0, j0, 4'b1100);
        cmp("lit_k_0110", 0, k0, 4'b1100);
`else
        cmp("lit_j_0110", 0, j0, 4'b0100);
        cmp("lit_k_0110", 0, k0, 4'b1000);
`endif
        tick(); #1;
        cmp("lit_q_0110", 0, q0, 4'b0110);

        // Parallel: target equal to q
        tick();
        wait_ready(0);
        valid_v[0] = 1'b1; data_v[0] = 4'b0110;
        tick();
        valid_v[0] = 1'b0;
        #1;
        cmp("lit_j_same", 0, j0, 4'b0000);
        cmp("lit_k_same", 0, k0, 4'b0000);
        tick(); #1;
        cmp("lit_done_same", 0, W'(done0), W'(1'b1));
        cmp("lit_mm_same", 0, W'(mm0), W'(1'b0));

        // Parallel: valid held through CHECK, data changed while busy
        tick();
        wait_ready(0);
        valid_v[0] = 1'b1; data_v[0] = 4'b0011;
        tick();
        data_v[0] = 4'b1100;
        #1;
        cmp("lit_busy_held", 0, W'(ready0), W'(1'b0));
        tick(); #1;
        cmp("lit_q_0011", 0, q0, 4'b0011);
        tick(); #1;
        cmp("lit_ready_again", 0, W'(ready0), W'(1'b1));
        tick();
        valid_v[0] = 1'b0;
        tick(); #1;
        cmp("lit_q_1100", 0, q0, 4'b1100);
        cmp("lit_done_1100", 0, W'(done0), W'(1'b1));

        // Serial: 0000 -> 1111, one bit per edge
        tick();
        wait_ready(1);
        valid_v[1] = 1'b1; data_v[1] = 4'b1111;
        tick();
        valid_v[1] = 1'b0;
        #1;
        cmp("lit_ser_q0", 1, q1, 4'b0000);
        cmp("lit_ser_j0", 1, j1, 4'b0001);
        tick(); #1; cmp("lit_ser_q1", 1, q1, 4'b0001);
        tick(); #1; cmp("lit_ser_q2", 1, q1, 4'b0011);
        tick(); #1; cmp("lit_ser_q3", 1, q1, 4'b0111);
        tick(); #1;
        cmp("lit_ser_q4", 1, q1, 4'b1111);
        cmp("lit_ser_done", 1, W'(done1), W'(1'b1));

        // Serial: reset after two excite cycles, then a clean application
        tick();
        wait_ready(1);
        valid_v[1] = 1'b1; data_v[1] = 4'b0000;
        tick();
        valid_v[1] = 1'b0;
        tick();
        tick();
        rst_v[1] = 1'b1;
        #1;
        cmp("lit_abort_q", 1, q1, 4'b0000);
        cmp("lit_abort_busy", 1, W'(busy1), W'(1'b0));
        cmp("lit_abort_done", 1, W'(done1), W'(1'b0));
        tick();
        rst_v[1] = 1'b0;
        #1;
        cmp("lit_abort_ready", 1, W'(ready1), W'(1'b1));
        tick();
        valid_v[1] = 1'b1; data_v[1] = 4'b0101;
        tick();
        valid_v[1] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick(); #1;
        cmp("lit_q_0101", 1, q1, 4'b0101);
        cmp("lit_done_0101", 1, W'(done1), W'(1'b1));

        // Randomized traffic with occasional resets on both instances
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                rst_v[d]   = ($urandom_range(0, 79) == 0);
                valid_v[d] = ($urandom_range(0, 3) != 0);
                data_v[d]  = W'($urandom_range(0, 15));
            end
        end
        tick();
        rst_v   = 2'b00;
        valid_v = 2'b00;
        for (int i = 0; i < 8; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
